// File: rtl/envelope_pwm_mixer.sv
// Per-voice attack/release envelopes, amplitude mixer and first-order
// sigma-delta 1-bit DAC driving the pwmout pin.
module envelope_pwm_voice #(
  parameter int ENV_BITS     = 8,
  parameter int ATTACK_STEP  = 16,
  parameter int RELEASE_STEP = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                gate,
  input  logic                tick,
  output logic [ENV_BITS-1:0] level,
  output logic                active
);
  localparam int EW1 = ENV_BITS + 1;
  localparam logic [ENV_BITS:0] ATK = EW1'(ATTACK_STEP);
  localparam logic [ENV_BITS:0] REL = EW1'(RELEASE_STEP);

  logic                gate_meta, gate_s;
  logic [ENV_BITS:0]   up, dn;
  logic [ENV_BITS-1:0] level_nxt;

  // One extra bit catches overflow/borrow so the ramp saturates instead of wrapping.
  always_comb begin
    up        = {1'b0, level} + ATK;
    dn        = {1'b0, level} - REL;
    level_nxt = level;
    if (tick) begin
      if (gate_s) level_nxt = up[ENV_BITS] ? '1 : up[ENV_BITS-1:0];
      else        level_nxt = dn[ENV_BITS] ? '0 : dn[ENV_BITS-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gate_meta <= 1'b0;
      gate_s    <= 1'b0;
      level     <= '0;
      active    <= 1'b0;
    end else begin
      gate_meta <= gate;
      gate_s    <= gate_meta;
      level     <= level_nxt;
      active    <= (level_nxt != '0);
    end
  end
endmodule

module envelope_pwm_mixer #(
  parameter int VOICES       = 3,
  parameter int ENV_BITS     = 8,
  parameter int RATE_DIV     = 1024,
  parameter int ATTACK_STEP  = 16,
  parameter int RELEASE_STEP = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [VOICES-1:0] gate,
  input  logic [VOICES-1:0] osc,
  output logic              pwmout,
  output logic [VOICES-1:0] env_active
);
  localparam int SUM_BITS = ENV_BITS + $clog2(VOICES);
  localparam int CNT_W    = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;

  logic [CNT_W-1:0]                   cnt;
  logic                               tick;
  logic [VOICES-1:0][ENV_BITS-1:0]    level;
  logic [SUM_BITS-1:0]                sum_nxt, sample, acc;
  logic [SUM_BITS:0]                  sd;

  assign tick = (cnt == CNT_W'(RATE_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + CNT_W'(1);
  end

  for (genvar i = 0; i < VOICES; i++) begin : g_voice
    envelope_pwm_voice #(
      .ENV_BITS    (ENV_BITS),
      .ATTACK_STEP (ATTACK_STEP),
      .RELEASE_STEP(RELEASE_STEP)
    ) u_voice (
      .clk   (clk),
      .rst   (rst),
      .gate  (gate[i]),
      .tick  (tick),
      .level (level[i]),
      .active(env_active[i])
    );
  end

  always_comb begin
    sum_nxt = '0;
    for (int i = 0; i < VOICES; i++)
      if (osc[i]) sum_nxt = sum_nxt + SUM_BITS'(level[i]);
  end

  // Carry out of the phase accumulator is the DAC bit; its density equals sample/2^SUM_BITS.
  assign sd = {1'b0, acc} + {1'b0, sample};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample <= '0;
      acc    <= '0;
      pwmout <= 1'b0;
    end else begin
      sample <= sum_nxt;
      acc    <= sd[SUM_BITS-1:0];
      pwmout <= sd[SUM_BITS];
    end
  end
endmodule
